// File: rtl/m_store_queue_pkg.sv
// m_store_queue_pkg: size codes and lane-geometry helpers shared by the store unit
package m_store_queue_pkg;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} sz_e;
  localparam int DATA_W_DEF = 32;
  localparam int NB = DATA_W_DEF / 8;
  localparam int OFF_W = $clog2(NB);
  function automatic int f_nb(int dw);
    return dw / 8;
  endfunction
  function automatic int f_off_w(int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/m_store_lane.sv
// m_store_lane: turns size/offset/data into byte enables, lane-shifted data and a misalign flag
module m_store_lane import m_store_queue_pkg::*; #(
  parameter int DATA_W = 32,
  localparam int NB = f_nb(DATA_W),
  localparam int OFF_W = f_off_w(DATA_W)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] data,
  output logic [NB-1:0]     byteen,
  output logic [DATA_W-1:0] wdata,
  output logic              misaligned
);
  logic [3:0] w_s;
  assign w_s = 4'd1 << size;
  assign byteen = NB'((16'd1 << w_s) - 16'd1) << off;
  assign wdata = (data & DATA_W'((64'd1 << {w_s, 3'b000}) - 64'd1)) << {off, 3'b000};
  // a dword never fits a 32-bit lane group, whatever its offset
  assign misaligned = |(OFF_W'(w_s - 4'd1) & off) || (size == SZ_D && DATA_W == 32);
endmodule

// File: rtl/m_store_queue.sv
// m_store_queue: store FIFO for the M stage with lane alignment, misalign trap and load-overlap detection
module m_store_queue import m_store_queue_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  localparam int NB = f_nb(DATA_W),
  localparam int OFF_W = f_off_w(DATA_W),
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_size,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [NB-1:0]     out_byteen,
  output logic [DATA_W-1:0] out_wdata,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [NB-1:0]     ld_byteen,
  output logic              ld_conflict,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] exc_addr,
  output logic [PW-1:0]     count
);
  logic [PW-1:0]     r_head, r_tail;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [NB-1:0]     r_be [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic              r_exc;
  logic [ADDR_W-1:0] r_exc_addr;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wd;
  logic              w_mis, w_acc, w_push, w_pop, w_hit;
  logic [PW-2:0]     w_hd;
  m_store_lane #(.DATA_W(DATA_W)) u_lane (
    .size(in_size), .off(in_addr[OFF_W-1:0]), .data(in_data),
    .byteen(w_be), .wdata(w_wd), .misaligned(w_mis)
  );
  assign count = r_tail - r_head;
  assign in_ready = count < PW'(DEPTH);
  assign out_valid = count != '0;
  assign w_acc = in_valid && in_ready;
  assign w_push = w_acc && !w_mis;
  assign w_pop = out_valid && out_ready;
  assign w_hd = r_head[PW-2:0];
  assign out_addr = out_valid ? r_addr[w_hd] : '0;
  assign out_byteen = out_valid ? r_be[w_hd] : '0;
  assign out_wdata = out_valid ? r_data[w_hd] : '0;
  assign exc_ades = r_exc;
  assign exc_addr = r_exc_addr;
  assign ld_conflict = ld_valid && w_hit;
  // walk the occupied window starting at head; the xor-shift compares line addresses
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (PW'(i) < count && ((r_addr[w_hd + (PW-1)'(i)] ^ ld_addr) >> OFF_W) == '0 &&
          |(r_be[w_hd + (PW-1)'(i)] & ld_byteen))
        w_hit = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_exc <= 1'b0;
      r_exc_addr <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      r_exc <= w_acc && w_mis;
      if (w_acc && w_mis) r_exc_addr <= in_addr;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail[PW-2:0]] <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      r_be[r_tail[PW-2:0]] <= w_be;
      r_data[r_tail[PW-2:0]] <= w_wd;
    end
  end
endmodule

// File: tb/tb_m_store_queue.sv
// tb_m_store_queue: directed and random stimulus against a queue-based store model
module tb_m_store_queue;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, ld_valid = 1'b0;
  logic [1:0] in_size = '0;
  logic [31:0] in_addr = '0, in_data = '0, ld_addr = '0;
  logic [3:0] ld_byteen = '0;
  logic in_ready, out_valid, ld_conflict, exc_ades;
  logic [31:0] out_addr, out_wdata, exc_addr;
  logic [3:0] out_byteen;
  logic [2:0] count;
  logic v64 = 1'b0;
  logic [1:0] sz64 = '0;
  logic [31:0] a64 = '0;
  logic [63:0] d64 = '0;
  logic rdy64, ov64, lc64, exc64;
  logic [31:0] oa64, ea64;
  logic [7:0] be64;
  logic [63:0] wd64;
  logic [2:0] cnt64;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [31:0] a; logic [3:0] be; logic [31:0] d;} ent_t;
  ent_t mq[$];
  logic m_exc = 1'b0;
  logic [31:0] m_exc_addr = '0;

  m_store_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_size(in_size),
    .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_byteen(out_byteen), .out_wdata(out_wdata), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_byteen(ld_byteen), .ld_conflict(ld_conflict), .exc_ades(exc_ades),
    .exc_addr(exc_addr), .count(count)
  );
  m_store_queue #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(v64), .in_ready(rdy64), .in_size(sz64),
    .in_addr(a64), .in_data(d64), .out_valid(ov64), .out_ready(1'b0),
    .out_addr(oa64), .out_byteen(be64), .out_wdata(wd64), .ld_valid(1'b0),
    .ld_addr(32'h0), .ld_byteen(8'h0), .ld_conflict(lc64), .exc_ades(exc64),
    .exc_addr(ea64), .count(cnt64)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_conflict();
    logic hit = 1'b0;
    foreach (mq[i])
      if ((mq[i].a >> 2) == (ld_addr >> 2) && (mq[i].be & ld_byteen) != 0) hit = 1'b1;
    return ld_valid && hit;
  endfunction

  task automatic check_all();
    chk("count", 64'(count), 64'(mq.size()));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 4));
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_addr", 64'(out_addr), 64'(mq[0].a));
      chk("out_byteen", 64'(out_byteen), 64'(mq[0].be));
      chk("out_wdata", 64'(out_wdata), 64'(mq[0].d));
    end else begin
      chk("idle_byteen", 64'(out_byteen), 64'h0);
      chk("idle_wdata", 64'(out_wdata), 64'h0);
    end
    chk("exc_ades", 64'(exc_ades), 64'(m_exc));
    chk("exc_addr", 64'(exc_addr), 64'(m_exc_addr));
    chk("ld_conflict", 64'(ld_conflict), 64'(model_conflict()));
  endtask

  // one clock: check outputs mid-cycle, predict the edge, then apply it to the model
  task automatic tick();
    ent_t e;
    int s, off;
    bit pop, acc, mis;
    @(negedge clk);
    check_all();
    s = 1 << in_size;
    off = int'(in_addr % 4);
    pop = (mq.size() > 0) && out_ready;
    acc = in_valid && (mq.size() < 4);
    mis = (in_addr % s) != 0 || in_size == 2'd3;
    e.a = in_addr & ~32'h3;
    e.be = '0;
    e.d = '0;
    for (int b = 0; b < s && b < 4; b++) begin
      e.be[off + b] = 1'b1;
      e.d[8*(off + b) +: 8] = in_data[8*b +: 8];
    end
    @(posedge clk);
    if (!reset) begin
      mq.delete();
      m_exc = 1'b0;
      m_exc_addr = '0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc && !mis) mq.push_back(e);
      m_exc = acc && mis;
      if (m_exc) m_exc_addr = in_addr;
    end
    #1;
  endtask

  task automatic put(logic v, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
    in_valid = v;
    in_size = sz;
    in_addr = a;
    in_data = d;
  endtask

  initial begin
    @(posedge clk);
    #1;
    tick();
    reset = 1'b1;
    tick();
    // lane generation
    out_ready = 1'b0;
    put(1'b1, 2'd0, 32'h0000_0103, 32'h0000_00AB);
    v64 = 1'b1; sz64 = 2'd3; a64 = 32'h8; d64 = 64'h1122_3344_5566_7788;
    tick();
    v64 = 1'b0;
    chk("lane_b_be", 64'(out_byteen), 64'h8);
    chk("lane_b_wd", 64'(out_wdata), 64'hAB00_0000);
    chk("d64_be", 64'(be64), 64'hFF);
    chk("d64_wd", wd64, 64'h1122_3344_5566_7788);
    chk("d64_addr", 64'(oa64), 64'h8);
    chk("d64_count", 64'(cnt64), 64'd1);
    out_ready = 1'b1;
    put(1'b1, 2'd1, 32'h0000_0102, 32'h0000_1234);
    tick();
    chk("lane_h_be", 64'(out_byteen), 64'hC);
    chk("lane_h_wd", 64'(out_wdata), 64'h1234_0000);
    put(1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    // misaligned and oversized stores
    put(1'b1, 2'd2, 32'h0000_1002, 32'hDEAD_BEEF);
    tick();
    chk("mis_exc", 64'(exc_ades), 64'h1);
    chk("mis_addr", 64'(exc_addr), 64'h1002);
    chk("mis_count", 64'(count), 64'h0);
    put(1'b1, 2'd3, 32'h0000_2000, 32'h1);
    tick();
    chk("dword_exc", 64'(exc_ades), 64'h1);
    chk("dword_addr", 64'(exc_addr), 64'h2000);
    put(1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    chk("exc_pulse_end", 64'(exc_ades), 64'h0);
    // backpressure: five pushes into four slots
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("bp_full_ready", 64'(in_ready), 64'h0);
      put(1'b1, 2'd2, 32'h4000 + 32'(4 * i), $urandom);
      tick();
    end
    chk("bp_count", 64'(count), 64'h4);
    put(1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    chk("bp_head_hold", 64'(out_addr), 64'h4000);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_drained", 64'(out_valid), 64'h0);
    // steady push+pop at count 2 across three pointer laps
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      put(1'b1, 2'd2, 32'h5000 + 32'(4 * i), $urandom);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      put(1'b1, 2'($urandom_range(0, 2)), 32'h6000 + 32'(8 * i), $urandom);
      tick();
      chk("pp_count", 64'(count), 64'h2);
    end
    put(1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    tick();
    // load overlap
    out_ready = 1'b0;
    put(1'b1, 2'd0, 32'h0000_2001, 32'h0000_005A);
    tick();
    put(1'b0, 2'd0, 32'h0, 32'h0);
    ld_valid = 1'b1; ld_addr = 32'h2000; ld_byteen = 4'b0010;
    #1 chk("cf_hit", 64'(ld_conflict), 64'h1);
    ld_byteen = 4'b0001;
    #1 chk("cf_lane_miss", 64'(ld_conflict), 64'h0);
    ld_addr = 32'h2004; ld_byteen = 4'b0010;
    #1 chk("cf_addr_miss", 64'(ld_conflict), 64'h0);
    ld_addr = 32'h2000;
    tick();
    out_ready = 1'b1;
    tick();
    chk("cf_drained", 64'(ld_conflict), 64'h0);
    ld_valid = 1'b0;
    // reset with entries pending
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 2'd2, 32'h7000 + 32'(4 * i), $urandom);
      tick();
    end
    put(1'b0, 2'd0, 32'h0, 32'h0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);
    chk("rst_d64", 64'(cnt64), 64'h0);
    // random traffic in a small address window so loads hit often
    for (int i = 0; i < 400; i++) begin
      put(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          32'h3000 + 32'($urandom_range(0, 15)), $urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr = 32'h3000 + 32'($urandom_range(0, 15));
      ld_byteen = 4'($urandom);
      reset = 1'($urandom_range(0, 60) != 0);
      tick();
    end
    reset = 1'b1;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
